// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Handshaked PC+instruction pipeline stage register with optional
//            2-entry skid buffer, stall/flush and occupancy count.
//            Define PIPE_STAGE_REG_PERF_EN to build the stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 PC_W        = 64,
    parameter int                 INSTR_W     = 32,
    parameter logic [INSTR_W-1:0] FLUSH_INSTR = 32'h0000_0013,
    parameter int                 SKID        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         count,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        bubble_cycles
);

    logic               r_main_v;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;

    logic               w_skid_v;
    logic [PC_W-1:0]    w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;

    logic w_clear;
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_main_load;

    assign w_clear     = rst | flush;
    assign w_out_fire  = r_main_v & out_ready & ~stall & ~flush;
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_main_load = ~r_main_v | w_out_fire;

    generate
        if (SKID != 0) begin : g_skid
            logic               r_skid_v;
            logic [PC_W-1:0]    r_skid_pc;
            logic [INSTR_W-1:0] r_skid_instr;

            // The skid slot only catches an input that main cannot take; it
            // is always older than anything still upstream.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_skid_v     <= 1'b0;
                    r_skid_pc    <= '0;
                    r_skid_instr <= FLUSH_INSTR;
                end else if (!stall) begin
                    if (w_in_fire && r_main_v && !w_out_fire) begin
                        r_skid_v     <= 1'b1;
                        r_skid_pc    <= in_pc;
                        r_skid_instr <= in_instr;
                    end else if (r_skid_v && w_main_load) begin
                        r_skid_v <= 1'b0;
                    end
                end
            end

            assign w_skid_v     = r_skid_v;
            assign w_skid_pc    = r_skid_pc;
            assign w_skid_instr = r_skid_instr;
            // Registered-only ready: no out_ready -> in_ready path.
            assign w_in_ready   = ~r_skid_v & ~stall & ~w_clear;
        end else begin : g_noskid
            assign w_skid_v     = 1'b0;
            assign w_skid_pc    = '0;
            assign w_skid_instr = FLUSH_INSTR;
            assign w_in_ready   = (~r_main_v | out_ready) & ~stall & ~w_clear;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_main_v     <= 1'b0;
            r_main_pc    <= '0;
            r_main_instr <= FLUSH_INSTR;
        end else if (!stall && w_main_load) begin
            if (w_skid_v) begin
                r_main_v     <= 1'b1;
                r_main_pc    <= w_skid_pc;
                r_main_instr <= w_skid_instr;
            end else if (w_in_fire) begin
                r_main_v     <= 1'b1;
                r_main_pc    <= in_pc;
                r_main_instr <= in_instr;
            end else begin
                r_main_v <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_v;
    assign out_pc    = r_main_pc;
    assign out_instr = r_main_instr;
    assign count     = {1'b0, r_main_v} + {1'b0, w_skid_v};

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= 32'h0;
            r_bubble_cycles <= 32'h0;
        end else begin
            if (stall && r_main_v && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (out_ready && !r_main_v && (r_bubble_cycles != 32'hFFFF_FFFF)) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`else
    assign stall_cycles  = 32'h0;
    assign bubble_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Scoreboard bench for pipe_stage_reg, SKID=1 and SKID=0 instances
//            driven side by side against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid      [2];
    logic        in_ready      [2];
    logic [63:0] in_pc         [2];
    logic [31:0] in_instr      [2];
    logic        stall         [2];
    logic        flush         [2];
    logic        out_valid     [2];
    logic        out_ready     [2];
    logic [63:0] out_pc        [2];
    logic [31:0] out_instr     [2];
    logic [1:0]  count         [2];
    logic [31:0] stall_cycles  [2];
    logic [31:0] bubble_cycles [2];

    pipe_stage_reg #(.SKID(1)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pc(in_pc[0]), .in_instr(in_instr[0]),
        .stall(stall[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_pc(out_pc[0]), .out_instr(out_instr[0]),
        .count(count[0]),
        .stall_cycles(stall_cycles[0]), .bubble_cycles(bubble_cycles[0])
    );

    pipe_stage_reg #(.SKID(0)) u_noskid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pc(in_pc[1]), .in_instr(in_instr[1]),
        .stall(stall[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_pc(out_pc[1]), .out_instr(out_instr[1]),
        .count(count[1]),
        .stall_cycles(stall_cycles[1]), .bubble_cycles(bubble_cycles[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: an ordered list of held entries per instance.
    logic [63:0] m_pc   [2][2];
    logic [31:0] m_ins  [2][2];
    int          m_n    [2];
    logic [63:0] l_pc   [2];
    logic [31:0] l_ins  [2];
    logic [31:0] m_stall[2];
    logic [31:0] m_bub  [2];
    logic        e_rdy  [2];

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; l_pc[k] = '0; l_ins[k] = c_nop; m_stall[k] = '0; m_bub[k] = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e_rdy[k] = !rst && !stall[k] && !flush[k] &&
                           ((k == 0) ? (m_n[k] < 2) : (m_n[k] == 0 || out_ready[k]));
                if (chk_en) begin
                    chk("in_ready", k, {63'h0, in_ready[k]}, {63'h0, e_rdy[k]});
                    chk("count", k, {62'h0, count[k]}, 64'(m_n[k]));
                    chk("out_valid", k, {63'h0, out_valid[k]}, {63'h0, (m_n[k] > 0)});
                    if (m_n[k] > 0) begin
                        chk("out_pc", k, out_pc[k], m_pc[k][0]);
                        chk("out_instr", k, {32'h0, out_instr[k]}, {32'h0, m_ins[k][0]});
                    end else begin
                        chk("idle_pc", k, out_pc[k], l_pc[k]);
                        chk("idle_instr", k, {32'h0, out_instr[k]}, {32'h0, l_ins[k]});
                    end
`ifdef PIPE_STAGE_REG_PERF_EN
                    chk("stall_cycles", k, {32'h0, stall_cycles[k]}, {32'h0, m_stall[k]});
                    chk("bubble_cycles", k, {32'h0, bubble_cycles[k]}, {32'h0, m_bub[k]});
`else
                    chk("stall_cycles", k, {32'h0, stall_cycles[k]}, 64'h0);
                    chk("bubble_cycles", k, {32'h0, bubble_cycles[k]}, 64'h0);
`endif
                end
                // Advance the model to what the coming rising edge produces.
                if (rst) begin
                    m_n[k] = 0; l_pc[k] = '0; l_ins[k] = c_nop; m_stall[k] = '0; m_bub[k] = '0;
                end else begin
                    if (stall[k] && m_n[k] > 0 && m_stall[k] != 32'hFFFF_FFFF) m_stall[k]++;
                    if (out_ready[k] && m_n[k] == 0 && m_bub[k] != 32'hFFFF_FFFF) m_bub[k]++;
                    if (flush[k]) begin
                        m_n[k] = 0; l_pc[k] = '0; l_ins[k] = c_nop;
                    end else if (!stall[k]) begin
                        if (out_ready[k] && m_n[k] > 0) begin
                            l_pc[k] = m_pc[k][0]; l_ins[k] = m_ins[k][0];
                            m_pc[k][0] = m_pc[k][1]; m_ins[k][0] = m_ins[k][1];
                            m_n[k]--;
                        end
                        if (in_valid[k] && e_rdy[k]) begin
                            m_pc[k][m_n[k]] = in_pc[k]; m_ins[k][m_n[k]] = in_instr[k];
                            m_n[k]++;
                        end
                    end
                end
            end
        end
    end

    // Upstream source: a new PC appears only after the previous one was taken.
    task automatic step();
        bit acc [2];
        for (int k = 0; k < 2; k++) acc[k] = in_valid[k] && in_ready[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                in_pc[k]    = in_pc[k] + 64'd4;
                in_instr[k] = $urandom;
            end
        end
    endtask

    task automatic ctl(input bit v, input bit r, input bit s, input bit f);
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = v; out_ready[k] = r; stall[k] = s; flush[k] = f;
        end
    endtask

    task automatic load_pc(input logic [63:0] pc);
        for (int k = 0; k < 2; k++) begin
            in_pc[k] = pc; in_instr[k] = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        load_pc(64'h0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Back-to-back streaming
        load_pc(64'h1000);
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        // Backpressure then release
        load_pc(64'h2000);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step();
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 8 && in_pc[0] != 64'h200C; n++) step();
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        // Fill, stall three cycles, then flush and stall together
        load_pc(64'h3000);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        ctl(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        ctl(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step();

        // Randomised traffic with occasional stall, flush and reset
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                stall[k]     = ($urandom_range(0, 9) == 0);
                flush[k]     = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        rst = 1'b0;
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

`ifdef PIPE_STAGE_REG_PERF_EN
        // Bubble counter saturation
        force u_skid.r_bubble_cycles = 32'hFFFF_FFFE;
        release u_skid.r_bubble_cycles;
        m_bub[0] = 32'hFFFF_FFFE;
        repeat (3) step();
        @(negedge clk);
        chk("bubble_sat", 0, {32'h0, bubble_cycles[0]}, 64'h0000_0000_FFFF_FFFF);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
